// File: rtl/fake_signal_gen.sv
// fake_signal_gen: multi-channel fake antenna source.
// Every RATIO clocks (while enabled) a seeded 32-bit Galois LFSR advances
// WIDTH steps and a new WIDTH-bit sample is presented together with a
// one-cycle strobe. The mode input selects independent noise, a correlated
// point source with per-channel delays, a walking one-hot, or quiet output.
// locked reports that the correlated history has been refilled since the
// last mode change.
module fake_signal_gen #(
    parameter int          WIDTH = 24,
    parameter int          RATIO = 12,
    parameter int          DEPTH = 8,
    parameter int          DBITS = 3,
    parameter logic [31:0] SEED  = 32'h0000ACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [1:0]             mode,
    input  logic [WIDTH*DBITS-1:0] delays,
    output logic                   strobe,
    output logic                   locked,
    output logic [WIDTH-1:0]       signal
);

    localparam int          CW       = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int          FW       = $clog2(DEPTH + 1);
    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [31:0] MASK     = 32'h80200003;

    typedef enum logic [1:0] {
        MODE_INDEP = 2'd0,
        MODE_CORR  = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_QUIET = 2'd3
    } mode_e;

    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      lfsr_q, lfsr_d;
    // Only DEPTH-1 past bits are stored: the oldest bit of the DEPTH-wide
    // window is always the one shifted out on the next tick.
    logic [DEPTH-2:0] hist_q;
    logic [DEPTH-1:0] hist_d;
    logic [WIDTH-1:0] walk_q, walk_d, walk_rot;
    logic [1:0]       mode_q;
    logic [FW-1:0]    fill_q, fill_d;
    logic [WIDTH-1:0] signal_q, signal_d;
    logic             strobe_q;
    logic             locked_q;
    logic [WIDTH-1:0] corr;
    logic             tick;
    logic             common_bit;
    mode_e            mode_sel;

    assign tick     = enable && (count_q == CW'(RATIO - 1));
    assign mode_sel = mode_e'(mode);

    // Sample-rate counter: wraps on tick, holds while enable is low.
    always_comb begin
        count_d = count_q;
        if (tick) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // LFSR advanced WIDTH Galois steps; its top bit is the common source bit.
    always_comb begin
        lfsr_d = lfsr_q;
        for (int s = 0; s < WIDTH; s++) begin
            if (lfsr_d[0]) begin
                lfsr_d = (lfsr_d >> 1) ^ MASK;
            end else begin
                lfsr_d = lfsr_d >> 1;
            end
        end
    end

    assign common_bit = lfsr_d[31];

    // Correlated history window as seen after this tick; bit k is k samples old.
    always_comb begin
        hist_d = {hist_q, common_bit};
    end

    // Per-channel delayed tap, delay clamped to the window length.
    always_comb begin
        corr = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if ((k == DEPTH - 1 && int'(delays[i*DBITS +: DBITS]) >= DEPTH - 1) ||
                    (int'(delays[i*DBITS +: DBITS]) == k)) begin
                    corr[i] = hist_d[k];
                end
            end
        end
    end

    // Walking one-hot rotated left, top channel wraps to channel 0.
    always_comb begin
        walk_rot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            walk_rot[(i + 1) % WIDTH] = walk_q[i];
        end
    end

    // Next output sample and walker position for the selected mode.
    always_comb begin
        signal_d = signal_q;
        walk_d   = walk_q;
        if (tick) begin
            case (mode_sel)
                MODE_INDEP: signal_d = lfsr_d[WIDTH-1:0];
                MODE_CORR:  signal_d = corr;
                MODE_WALK: begin
                    signal_d = walk_q;
                    walk_d   = walk_rot;
                end
                default:    signal_d = '0;
            endcase
        end
    end

    // History fill level: a mode change restarts it, otherwise ticks count up to DEPTH.
    always_comb begin
        fill_d = fill_q;
        if (mode != mode_q) begin
            fill_d = '0;
        end else if (tick && (fill_q != FW'(DEPTH))) begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Sample-clock state; LFSR and history advance on every tick in all modes.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            lfsr_q  <= SEED_EFF;
            hist_q  <= '0;
            walk_q  <= WIDTH'(1);
        end else begin
            count_q <= count_d;
            if (tick) begin
                lfsr_q <= lfsr_d;
                hist_q <= hist_d[DEPTH-2:0];
                walk_q <= walk_d;
            end
        end
    end

    // Registered outputs and mode/fill tracking.
    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q   <= 2'd0;
            fill_q   <= '0;
            signal_q <= '0;
            strobe_q <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            mode_q   <= mode;
            fill_q   <= fill_d;
            signal_q <= signal_d;
            strobe_q <= tick;
            locked_q <= (fill_d == FW'(DEPTH));
        end
    end

    assign signal = signal_q;
    assign strobe = strobe_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_fake_signal_gen.sv
// Directed testbench for fake_signal_gen (WIDTH=24, RATIO=12, DEPTH=8).
// A second instance with SEED=0 runs alongside to show it behaves as SEED=1.
module tb_fake_signal_gen;

    localparam int          WIDTH   = 24;
    localparam int          RATIO   = 12;
    localparam int          DEPTH   = 8;
    localparam int          DBITS   = 4;
    localparam int          DBITS_Z = 3;
    localparam logic [31:0] SEED    = 32'h0000ACE1;

    logic                     clock = 1'b0;
    logic                     reset = 1'b1;
    logic                     enable = 1'b0;
    logic [1:0]               mode = 2'd0;
    logic [WIDTH*DBITS-1:0]   delays = '0;
    logic [WIDTH*DBITS_Z-1:0] delays_z = '0;
    logic                     strobe, locked;
    logic [WIDTH-1:0]         signal;
    logic                     strobe_z, locked_z;
    logic [WIDTH-1:0]         signal_z;

    int total = 0;
    int bad   = 0;

    fake_signal_gen #(.WIDTH(WIDTH), .RATIO(RATIO), .DEPTH(DEPTH), .DBITS(DBITS), .SEED(SEED)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .delays(delays),
        .strobe(strobe), .locked(locked), .signal(signal)
    );

    fake_signal_gen #(.WIDTH(WIDTH), .RATIO(RATIO), .DEPTH(DEPTH), .DBITS(DBITS_Z), .SEED(32'h0)) dut_z (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .delays(delays_z),
        .strobe(strobe_z), .locked(locked_z), .signal(signal_z)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // Reference LFSR: 32-bit Galois, mask 80200003, WIDTH steps per tick.
    function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
        logic [31:0] v;
        v = s;
        for (int k = 0; k < WIDTH; k++) begin
            if (v[0]) v = (v >> 1) ^ 32'h80200003;
            else      v = v >> 1;
        end
        return v;
    endfunction

    task automatic apply_reset(input logic [1:0] m, input logic en);
        @(negedge clock);
        reset  = 1'b1;
        mode   = m;
        enable = en;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3 * RATIO; k++) begin
            @(negedge clock);
            if (strobe === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL strobe_timeout: no strobe within %0d cycles, required one", 3 * RATIO);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset  = 1'b1;
        enable = 1'b1;
        mode   = 2'd2;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (signal !== '0) begin
            bad++;
            $display("FAIL reset_signal: got %h, required 000000", signal);
        end
        total++;
        if (strobe !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobe: got %b, required 0", strobe);
        end
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL reset_locked: got %b, required 0", locked);
        end
    endtask

    task automatic test_cadence();
        logic [WIDTH-1:0] prev;
        logic             exp_s;
        apply_reset(2'd0, 1'b1);
        prev = signal;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clock);
            exp_s = ((cyc % RATIO) == 0);
            total++;
            if (strobe !== exp_s) begin
                bad++;
                $display("FAIL cadence_strobe: cycle %0d got %b, required %b", cyc, strobe, exp_s);
            end
            total++;
            if (strobe !== 1'b1 && signal !== prev) begin
                bad++;
                $display("FAIL cadence_hold: cycle %0d signal %h changed from %h without strobe", cyc, signal, prev);
            end
            prev = signal;
        end
    endtask

    task automatic test_determinism();
        logic [WIDTH-1:0] run1[16];
        logic [31:0]      m, m1;
        bit               ok;
        apply_reset(2'd0, 1'b1);
        m  = SEED;
        m1 = 32'd1;
        for (int n = 0; n < 16; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            m  = lfsr_adv(m);
            m1 = lfsr_adv(m1);
            run1[n] = signal;
            total++;
            if (signal !== m[WIDTH-1:0]) begin
                bad++;
                $display("FAIL det_model: word %0d got %h, required %h", n, signal, m[WIDTH-1:0]);
            end
            total++;
            if (signal_z !== m1[WIDTH-1:0]) begin
                bad++;
                $display("FAIL det_seed0: word %0d got %h, required %h", n, signal_z, m1[WIDTH-1:0]);
            end
        end
        apply_reset(2'd0, 1'b1);
        for (int n = 0; n < 16; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            total++;
            if (signal !== run1[n]) begin
                bad++;
                $display("FAIL det_rerun: word %0d got %h, required %h", n, signal, run1[n]);
            end
        end
    endtask

    task automatic set_corr_delays();
        delays = '0;
        delays[1*DBITS +: DBITS] = 4'd3;
        delays[2*DBITS +: DBITS] = 4'd9;
    endtask

    task automatic test_correlated();
        logic        ch0_q[$];
        logic [31:0] m;
        bit          ok;
        set_corr_delays();
        apply_reset(2'd1, 1'b1);
        m = SEED;
        for (int n = 1; n <= 108; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            m = lfsr_adv(m);
            ch0_q.push_back(signal[0]);
            total++;
            if (signal[0] !== m[31]) begin
                bad++;
                $display("FAIL corr_ch0: tick %0d got %b, required %b", n, signal[0], m[31]);
            end
            if (n == 8) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL corr_locked: tick 8 got %b, required 1", locked);
                end
            end
            if (n > 8) begin
                total++;
                if (signal[1] !== ch0_q[n-4]) begin
                    bad++;
                    $display("FAIL corr_ch1: tick %0d got %b, required %b", n, signal[1], ch0_q[n-4]);
                end
                total++;
                if (signal[2] !== ch0_q[n-8]) begin
                    bad++;
                    $display("FAIL corr_ch2: tick %0d got %b, required %b", n, signal[2], ch0_q[n-8]);
                end
            end
        end
    endtask

    task automatic test_walking();
        bit ok;
        apply_reset(2'd2, 1'b1);
        for (int n = 1; n <= 25; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            if (n == 1 || n == 25) begin
                total++;
                if (signal !== 24'h000001) begin
                    bad++;
                    $display("FAIL walk_first: strobe %0d got %h, required 000001", n, signal);
                end
            end
            if (n == 2) begin
                total++;
                if (signal !== 24'h000002) begin
                    bad++;
                    $display("FAIL walk_second: got %h, required 000002", signal);
                end
            end
            if (n == 24) begin
                total++;
                if (signal !== 24'h800000) begin
                    bad++;
                    $display("FAIL walk_top: got %h, required 800000", signal);
                end
            end
            if (n == 7) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL walk_unlocked: tick 7 got %b, required 0", locked);
                end
            end
            if (n == 8) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL walk_locked: tick 8 got %b, required 1", locked);
                end
            end
        end
    endtask

    task automatic test_mode_change_gap();
        logic [WIDTH-1:0] sig_hold;
        logic             lck_hold;
        bit               ok;
        delays = '0;
        apply_reset(2'd0, 1'b1);
        for (int n = 0; n < 9; n++) begin
            wait_strobe(ok);
        end
        total++;
        if (locked !== 1'b1) begin
            bad++;
            $display("FAIL mc_pre_locked: got %b, required 1", locked);
        end
        repeat (3) @(negedge clock);
        mode = 2'd1;
        @(negedge clock);
        total++;
        if (locked !== 1'b0) begin
            bad++;
            $display("FAIL mc_drop: got %b, required 0", locked);
        end
        for (int n = 1; n <= 8; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            if (n == 7) begin
                total++;
                if (locked !== 1'b0) begin
                    bad++;
                    $display("FAIL mc_early: tick 7 got %b, required 0", locked);
                end
            end
            if (n == 8) begin
                total++;
                if (locked !== 1'b1) begin
                    bad++;
                    $display("FAIL mc_relock: tick 8 got %b, required 1", locked);
                end
            end
        end
        repeat (4) @(negedge clock);
        sig_hold = signal;
        lck_hold = locked;
        enable   = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clock);
            total++;
            if (strobe !== 1'b0 || signal !== sig_hold || locked !== lck_hold) begin
                bad++;
                $display("FAIL gap_hold: cycle %0d strobe=%b signal=%h locked=%b, required 0 %h %b",
                         k, strobe, signal, locked, sig_hold, lck_hold);
            end
        end
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            total++;
            if (strobe !== (k == 8)) begin
                bad++;
                $display("FAIL gap_resume: cycle %0d strobe=%b, required %b", k, strobe, (k == 8));
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [WIDTH-1:0] cold[10];
        int               at;
        bit               ok;
        set_corr_delays();
        apply_reset(2'd1, 1'b1);
        for (int n = 0; n < 10; n++) begin
            wait_strobe(ok);
            cold[n] = signal;
        end
        repeat (5) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if (signal !== '0 || strobe !== 1'b0 || locked !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: signal=%h strobe=%b locked=%b, required 000000 0 0", signal, strobe, locked);
        end
        reset = 1'b0;
        at = 0;
        for (int k = 1; k <= 3 * RATIO; k++) begin
            @(negedge clock);
            if (strobe === 1'b1) begin
                at = k;
                break;
            end
        end
        total++;
        if (at != RATIO) begin
            bad++;
            $display("FAIL mid_first_strobe: at cycle %0d, required %0d", at, RATIO);
        end
        total++;
        if (signal !== cold[0]) begin
            bad++;
            $display("FAIL mid_word: word 0 got %h, required %h", signal, cold[0]);
        end
        for (int n = 1; n < 10; n++) begin
            wait_strobe(ok);
            if (!ok) break;
            total++;
            if (signal !== cold[n]) begin
                bad++;
                $display("FAIL mid_word: word %0d got %h, required %h", n, signal, cold[n]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cadence();
        test_determinism();
        test_correlated();
        test_walking();
        test_mode_change_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
